// File: rtl/vme_pkg.sv
// Shared definitions for the VME interrupter: line polarities, FSM states, IRQ bus width.
package vme_pkg;

   // Active-low bus and device lines
   localparam logic ACTIVE   = 1'b0;
   localparam logic INACTIVE = 1'b1;

   // IRQ7..IRQ1
   localparam int unsigned IRQ_W = 7;

   typedef enum logic [2:0] {
      IDLE,
      DECIDE,
      PASS,
      RESPOND,
      ACK,
      DONE,
      RELEASE
   } irq_state_e;

   // One-hot IRQ line image for a level (1..7) carrying the given request
   function automatic logic [IRQ_W-1:0] irq_lines(input logic [2:0] level, input logic req);
      logic [IRQ_W-1:0] l;
      l = '0;
      for (int unsigned i = 0; i < IRQ_W; i++) begin
         l[i] = req && ((i + 1) == 32'(level));
      end
      return l;
   endfunction

endpackage

// File: rtl/vme_interrupter_if.sv
// VME bus signals seen by a slave-card interrupter (IRQ, IACK daisy chain, strobes, D7-D0).
interface vme_interrupter_if;

   logic                      vme_as;
   logic                      vme_ds0;
   logic [2:0]                vme_address;
   logic                      vme_iackin;
   logic                      vme_iackout;
   logic                      vme_dtack;
   logic [7:0]                vme_data_out;
   logic                      vme_data_oe;
   logic [vme_pkg::IRQ_W-1:0] vme_irq;

   modport slave (
      input  vme_as, vme_ds0, vme_address, vme_iackin,
      output vme_iackout, vme_dtack, vme_data_out, vme_data_oe, vme_irq
   );

   modport master (
      output vme_as, vme_ds0, vme_address, vme_iackin,
      input  vme_iackout, vme_dtack, vme_data_out, vme_data_oe, vme_irq
   );

endinterface

// File: rtl/vme_interrupter_sync.sv
// Two-flop synchronizer for an asynchronous active-low bus strobe; resets to the released level.
module signal_sync
   import vme_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q <= INACTIVE;
         sync_q <= INACTIVE;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/vme_interrupter.sv
// VME ROAK interrupter: raises IRQ for a local request, answers the IACK cycle for its own
// level with a status/ID vector, and passes the daisy chain on for every other case.
module vme_interrupter
   import vme_pkg::*;
#(
   parameter logic [2:0]  IRQ_LEVEL   = 3'd2,
   parameter int unsigned DTACK_DELAY = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               dev_irq,
   output logic               dev_iack,
   input  logic [7:0]         vector_id,
   vme_interrupter_if.slave   vme
);

   localparam logic [2:0] DLY_LAST = 3'(DTACK_DELAY - 1);

   logic       as_s;
   logic       ds0_s;
   logic       iackin_s;

   irq_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       pending_q, pending_d;
   logic       armed_q, armed_d;
   logic       req_now;

   signal_sync u_sync_as     (.clock(clock), .reset(reset), .d_i(vme.vme_as),     .q_o(as_s));
   signal_sync u_sync_ds0    (.clock(clock), .reset(reset), .d_i(vme.vme_ds0),    .q_o(ds0_s));
   signal_sync u_sync_iackin (.clock(clock), .reset(reset), .d_i(vme.vme_iackin), .q_o(iackin_s));

   // Request bookkeeping: set while armed and requested, cleared with arming on vector acceptance
   always_comb begin
      req_now   = pending_q | ((dev_irq == ACTIVE) & armed_q);
      pending_d = req_now;
      armed_d   = armed_q | (dev_irq == INACTIVE);
      if (state_q == DONE) begin
         pending_d = 1'b0;
         armed_d   = 1'b0;
      end
   end

   // IACK cycle next-state, address capture, vector load and DTACK delay counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;

      if (state_q == IDLE && iackin_s == ACTIVE) begin
         addr_d = vme.vme_address;
      end

      case (state_q)
         IDLE: begin
            if (iackin_s == ACTIVE && as_s == ACTIVE) begin
               state_d = DECIDE;
            end
         end
         DECIDE: begin
            // A request landing in this very clock still counts for the decision
            if (req_now && addr_q == IRQ_LEVEL) begin
               state_d = RESPOND;
               cnt_d   = '0;
               data_d  = vector_id;
            end else begin
               state_d = PASS;
            end
         end
         PASS: begin
            if (as_s == INACTIVE) begin
               state_d = RELEASE;
            end
         end
         RESPOND: begin
            if (as_s == INACTIVE || iackin_s == INACTIVE) begin
               state_d = RELEASE;
            end else if (ds0_s == ACTIVE) begin
               if (cnt_q == DLY_LAST) begin
                  state_d = ACK;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         ACK: begin
            if (ds0_s == INACTIVE) begin
               state_d = DONE;
            end else if (as_s == INACTIVE || iackin_s == INACTIVE) begin
               state_d = RELEASE;
            end
         end
         DONE: begin
            state_d = RELEASE;
         end
         RELEASE: begin
            if (as_s == INACTIVE && iackin_s == INACTIVE) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         pending_q <= 1'b0;
         armed_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
         armed_q   <= armed_d;
      end
   end

   // Bus outputs decode directly from state so reset releases them on the same edge
   assign vme.vme_irq      = irq_lines(IRQ_LEVEL, pending_q);
   assign vme.vme_iackout  = (state_q == PASS) ? ACTIVE : INACTIVE;
   assign vme.vme_dtack    = (state_q == ACK);
   assign vme.vme_data_oe  = (state_q == RESPOND) || (state_q == ACK);
   assign vme.vme_data_out = data_q;
   assign dev_iack         = (state_q == DONE) ? ACTIVE : INACTIVE;

endmodule

// File: tb/tb_vme_interrupter.sv
// Self-checking bench for vme_interrupter: directed protocol cases plus randomized IACK cycles
// checked against a transaction-level model of the request and acknowledge rules.
module tb_vme_interrupter;

   localparam logic [2:0]  LVL = 3'd2;
   localparam int unsigned DLY = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       dev_irq;
   logic       dev_iack;
   logic [7:0] vector_id;

   vme_interrupter_if bus ();

   vme_interrupter #(
      .IRQ_LEVEL   (LVL),
      .DTACK_DELAY (DLY)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .dev_irq   (dev_irq),
      .dev_iack  (dev_iack),
      .vector_id (vector_id),
      .vme       (bus)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Model state: outstanding request, re-arm flag, expected DONE cycle
   bit m_pending = 1'b0;
   bit m_armed   = 1'b1;
   bit exp_done  = 1'b0;
   int ack_cd    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_irq();
      logic [6:0] v;
      v = '0;
      if (m_pending) v[LVL-3'd1] = 1'b1;
      return v;
   endfunction

   // One clock: advance the model by the request rules, then check the continuously observable outputs
   task automatic step();
      logic d, r, was_done;
      d        = dev_irq;
      r        = reset;
      was_done = exp_done;
      @(posedge clock);
      #2;
      if (!r) begin
         m_pending = 1'b0;
         m_armed   = 1'b1;
         exp_done  = 1'b0;
         ack_cd    = 0;
      end else begin
         if (was_done) begin
            m_pending = 1'b0;
            m_armed   = 1'b0;
         end else begin
            if (!d && m_armed) m_pending = 1'b1;
            if (d) m_armed = 1'b1;
         end
         exp_done = 1'b0;
         if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) exp_done = 1'b1;
         end
      end
      check_eq("vme_irq", 32'(bus.vme_irq), 32'(exp_irq()));
      check_eq("dev_iack", 32'(dev_iack), exp_done ? 32'd0 : 32'd1);
      check_eq("iack_interlock", 32'(!bus.vme_iackout && (bus.vme_data_oe || bus.vme_dtack)), 32'd0);
   endtask

   task automatic bus_idle();
      bus.vme_as     = 1'b1;
      bus.vme_ds0    = 1'b1;
      bus.vme_iackin = 1'b1;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_irq", 32'(bus.vme_irq), 32'd0);
      check_eq("rst_iackout", 32'(bus.vme_iackout), 32'd1);
      check_eq("rst_dtack", 32'(bus.vme_dtack), 32'd0);
      check_eq("rst_oe", 32'(bus.vme_data_oe), 32'd0);
      check_eq("rst_data", 32'(bus.vme_data_out), 32'd0);
      check_eq("rst_dev_iack", 32'(dev_iack), 32'd1);
   endtask

   // Full IACK cycle; expected path comes from the model's pending bit and the acknowledged level
   task automatic iack_cycle(input logic [2:0] addr, input logic [7:0] vec, input bit abort);
      bit respond;
      bit seen;
      int t;
      respond        = m_pending && (addr == LVL);
      vector_id      = vec;
      bus.vme_address = addr;
      bus.vme_as     = 1'b0;
      bus.vme_ds0    = 1'b0;
      bus.vme_iackin = 1'b0;
      t    = 0;
      seen = 1'b0;
      if (respond) begin
         while (!seen && t < 20) begin
            step(); t++;
            if (bus.vme_data_oe) seen = 1'b1;
         end
         check_eq("oe_latency", 32'(t), 32'd4);
         check_eq("data_out", 32'(bus.vme_data_out), 32'(vec));
         vector_id = ~vec;
         seen = 1'b0;
         while (!seen && t < 30) begin
            step(); t++;
            if (bus.vme_dtack) seen = 1'b1;
         end
         check_eq("dtack_latency", 32'(t), 32'(4 + DLY));
         check_eq("data_held", 32'(bus.vme_data_out), 32'(vec));
         check_eq("oe_at_dtack", 32'(bus.vme_data_oe), 32'd1);
         if (abort) begin
            bus.vme_as = 1'b1;
         end else begin
            bus.vme_ds0 = 1'b1;
            ack_cd = 3;
         end
         t    = 0;
         seen = 1'b0;
         while (!seen && t < 10) begin
            step(); t++;
            if (!bus.vme_dtack) seen = 1'b1;
         end
         check_eq("dtack_drop", 32'(t), 32'd3);
         check_eq("oe_drop", 32'(bus.vme_data_oe), 32'd0);
      end else begin
         while (!seen && t < 20) begin
            step(); t++;
            if (!bus.vme_iackout) seen = 1'b1;
         end
         check_eq("iackout_latency", 32'(t), 32'd4);
         repeat (3) begin
            step();
            check_eq("iackout_held", 32'(bus.vme_iackout), 32'd0);
            check_eq("pass_dtack", 32'(bus.vme_dtack), 32'd0);
            check_eq("pass_oe", 32'(bus.vme_data_oe), 32'd0);
         end
         bus.vme_as = 1'b1;
         t    = 0;
         seen = 1'b0;
         while (!seen && t < 10) begin
            step(); t++;
            if (bus.vme_iackout) seen = 1'b1;
         end
         check_eq("iackout_release", 32'(t), 32'd3);
      end
      bus_idle();
      repeat (5) step();
   endtask

   initial begin
      logic [2:0] a;
      bit         seen;
      int         t;

      reset           = 1'b0;
      dev_irq         = 1'b1;
      vector_id       = '0;
      bus.vme_address = '0;
      bus_idle();
      repeat (2) step();
      check_reset_outputs();
      reset = 1'b1;
      step();

      // Request raises only the configured IRQ line
      dev_irq = 1'b0;
      repeat (2) step();
      check_eq("irq_level2", 32'(bus.vme_irq), 32'h02);

      // Other level acknowledged while pending: pass on, keep IRQ
      iack_cycle(3'd5, 8'hA5, 1'b0);
      // Own level: vector, DTACK, device acknowledge
      iack_cycle(3'd2, 8'h4C, 1'b0);

      // Held request must not re-request; release and reassert does
      repeat (3) step();
      check_eq("no_rerequest", 32'(bus.vme_irq), 32'h00);
      dev_irq = 1'b1;
      step();
      dev_irq = 1'b0;
      repeat (2) step();
      check_eq("rerequest", 32'(bus.vme_irq), 32'h02);
      iack_cycle(3'd2, 8'h11, 1'b0);

      // No request: own level and another level both pass on
      iack_cycle(3'd2, 8'h33, 1'b0);
      iack_cycle(3'd7, 8'h77, 1'b0);

      // Abort during ACK keeps the request
      dev_irq = 1'b1;
      step();
      dev_irq = 1'b0;
      repeat (2) step();
      iack_cycle(3'd2, 8'h5A, 1'b1);
      check_eq("abort_keeps_irq", 32'(bus.vme_irq), 32'h02);

      // Reset while responding releases every line next clock
      vector_id       = 8'h99;
      bus.vme_address = 3'd2;
      bus.vme_as      = 1'b0;
      bus.vme_ds0     = 1'b0;
      bus.vme_iackin  = 1'b0;
      t    = 0;
      seen = 1'b0;
      while (!seen && t < 20) begin
         step(); t++;
         if (bus.vme_data_oe) seen = 1'b1;
      end
      check_eq("respond_reached", 32'(bus.vme_data_oe), 32'd1);
      reset = 1'b0;
      bus_idle();
      step();
      check_reset_outputs();
      reset   = 1'b1;
      dev_irq = 1'b1;
      repeat (3) step();

      // Randomized request levels, acknowledged levels, vectors and aborts
      repeat (40) begin
         dev_irq = 1'($urandom_range(0, 1));
         repeat ($urandom_range(2, 4)) step();
         a = ($urandom_range(0, 1) == 1) ? LVL : 3'($urandom_range(1, 7));
         iack_cycle(a, 8'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
